// File: rtl/block_dist_pkg.sv
// Shared types for the block write distributor: FSM states, distribution mode,
// and a counter-width helper that stays legal for single-entry counters.
package block_dist_pkg;

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
  typedef enum logic {MODE_PARALLEL, MODE_SERIAL} dist_mode_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/block_write_addr_gen.sv
// Write address / block-select counters for one bank fill, with wrap and
// last-word detection for both parallel and serial distribution.
module block_write_addr_gen
  import block_dist_pkg::*;
#(
  parameter int BLOCK_COUNT = 4,
  parameter int BLOCK_DEPTH = 256,
  parameter int ADDR_WIDTH  = $clog2(BLOCK_DEPTH),
  parameter int BLK_WIDTH   = cnt_w(BLOCK_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_adv,
  input  logic                  i_serial,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [BLK_WIDTH-1:0]  o_blk,
  output logic                  o_last
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BLK_WIDTH-1:0]  r_blk;
  logic                  w_addr_last;
  logic                  w_blk_last;

  assign w_addr_last = (r_addr == ADDR_WIDTH'(BLOCK_DEPTH - 1));
  assign w_blk_last  = (r_blk == BLK_WIDTH'(BLOCK_COUNT - 1));
  assign o_last      = w_addr_last && (!i_serial || w_blk_last);
  assign o_addr      = r_addr;
  assign o_blk       = r_blk;

  // Clear has priority: a beat accepted with start was already issued at the
  // current address, so the counters restart from zero regardless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_blk  <= '0;
    end else if (i_clear) begin
      r_addr <= '0;
      r_blk  <= '0;
    end else if (i_adv) begin
      if (i_serial && !w_blk_last) begin
        r_blk <= r_blk + 1'b1;
      end else begin
        r_blk  <= '0;
        r_addr <= w_addr_last ? '0 : r_addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_write_distributor.sv
// Distributes input beats into BLOCK_COUNT block RAMs (parallel or serial mode),
// tracks bank fill. Optional sticky overflow flag: BLOCK_WRITE_DISTRIBUTOR_OVERFLOW_EN.
module block_write_distributor
  import block_dist_pkg::*;
#(
  parameter int BLOCK_COUNT      = 4,
  parameter int BLOCK_DATA_WIDTH = 32,
  parameter int BLOCK_DEPTH      = 256,
  parameter int BANDWIDTH        = BLOCK_COUNT * BLOCK_DATA_WIDTH,
  parameter int ADDR_WIDTH       = $clog2(BLOCK_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        mode,
  input  logic [BANDWIDTH-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [BLOCK_COUNT-1:0]      wr_en,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [BLOCK_DATA_WIDTH-1:0] wr_data [BLOCK_COUNT],
  output logic                        full,
  output logic                        done
`ifdef BLOCK_WRITE_DISTRIBUTOR_OVERFLOW_EN
  ,
  output logic                        overflow
`endif
);

  localparam int BLK_WIDTH = cnt_w(BLOCK_COUNT);

  state_t                      r_state;
  state_t                      w_state_nxt;
  dist_mode_t                  r_mode;
  logic                        w_fire;
  logic                        w_serial;
  logic                        w_last;
  logic [ADDR_WIDTH-1:0]       w_addr;
  logic [BLK_WIDTH-1:0]        w_blk;
  logic [BLOCK_COUNT-1:0]      w_en;
  logic [BLOCK_DATA_WIDTH-1:0] w_data [BLOCK_COUNT];

  assign in_ready = (r_state == FILL);
  assign full     = (r_state == FULL);
  assign w_fire   = in_valid && in_ready;
  assign w_serial = (r_mode == MODE_SERIAL);

  // start wins over the last-beat transition, so a restart never shows full.
  always_comb begin
    w_state_nxt = r_state;
    if (start)
      w_state_nxt = FILL;
    else if (w_fire && w_last)
      w_state_nxt = FULL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mode  <= MODE_PARALLEL;
    end else begin
      r_state <= w_state_nxt;
      if (start)
        r_mode <= dist_mode_t'(mode);
    end
  end

  block_write_addr_gen #(
    .BLOCK_COUNT (BLOCK_COUNT),
    .BLOCK_DEPTH (BLOCK_DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BLK_WIDTH   (BLK_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (start),
    .i_adv    (w_fire),
    .i_serial (w_serial),
    .o_addr   (w_addr),
    .o_blk    (w_blk),
    .o_last   (w_last)
  );

  // Serial mode broadcasts the low word; only the selected block strobes.
  always_comb begin
    for (int i = 0; i < BLOCK_COUNT; i++) begin
      w_data[i] = w_serial ? in_data[BLOCK_DATA_WIDTH-1:0]
                           : in_data[(i+1)*BLOCK_DATA_WIDTH-1 -: BLOCK_DATA_WIDTH];
      w_en[i]   = w_fire && (!w_serial || (w_blk == BLK_WIDTH'(i)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= '0;
      wr_addr <= '0;
      done    <= 1'b0;
      for (int i = 0; i < BLOCK_COUNT; i++)
        wr_data[i] <= '0;
    end else begin
      wr_en <= w_en;
      done  <= w_fire && w_last;
      if (w_fire) begin
        wr_addr <= w_addr;
        for (int i = 0; i < BLOCK_COUNT; i++)
          wr_data[i] <= w_data[i];
      end
    end
  end

`ifdef BLOCK_WRITE_DISTRIBUTOR_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_overflow <= 1'b0;
    else if (start)
      r_overflow <= 1'b0;
    else if (in_valid && (r_state != FILL))
      r_overflow <= 1'b1;
  end

  assign overflow = r_overflow;
`endif

endmodule
